imm_ext_pipe: RTL and testbench

Registered, parametrised immediate extender for the RISC-V core's next (pipelined) generation. Decodes the I, S, B, U and J immediate formats from a 32-bit instruction and sign-extends the result to XLEN. Sits between the decode stage and the execute operand mux, behind a valid/ready handshake with a 2-entry skid buffer, so back-pressure from execute never forms a combinational ready path into decode.

---
 rtl/imm_ext_pkg.sv | 25 ++
 rtl/imm_decode.sv | 43 ++++
 rtl/imm_ext_pipe.sv | 154 +++++++++++++++
 tb/tb_imm_ext_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared encodings for the registered immediate extender: format selects,
// skid-buffer state and statistics counter width.
package imm_ext_pkg;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam int NUM_FMT = 5;
  localparam int STAT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode (I/S/B/U/J) with sign extension to XLEN.
// Shared with the branch-target adder, so it carries no state.
module imm_decode
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic        s;
  logic [31:0] imm32;

  assign s = instr_i[31];

  always_comb begin
    imm32     = '0;
    illegal_o = 1'b0;
    case (imm_src_i)
      IMM_I:   imm32 = {{20{s}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: illegal_o = 1'b1;
    endcase
  end

  // Every format is already sign-correct at 32 bits, so widening is a plain
  // replication of bit 31 (this also gives U-type its upper bits on RV64).
  always_comb begin
    imm_o        = {XLEN{imm32[31]}};
    imm_o[31:0]  = imm32;
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer between decode and execute.
// Optional per-format output counters are built when IMM_EXT_PIPE_STATS_EN is defined.
//
// state | meaning
// EMPTY | main empty, skid empty; in_ready=1, out_valid=0
// ONE   | main holds the output word, skid empty; in_ready=1, out_valid=1
// FULL  | main stalled, skid holds the next word; in_ready=0, out_valid=1
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_illegal
`ifdef IMM_EXT_PIPE_STATS_EN
  ,
  output logic [NUM_FMT*STAT_W-1:0] stat_cnt,
  output logic [STAT_W-1:0]         stat_illegal
`endif
);

  if (ILEN != 32) begin : g_ilen_chk
    $error("imm_ext_pipe: ILEN must be 32");
  end

  typedef struct packed {
`ifdef IMM_EXT_PIPE_STATS_EN
    logic [2:0]      src;
`endif
    logic            ill;
    logic [XLEN-1:0] imm;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  entry_t          dec_entry;

  skid_state_e state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        in_fire;
  logic        out_fire;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr),
    .imm_src_i (imm_src),
    .imm_o     (dec_imm),
    .illegal_o (dec_ill)
  );

  always_comb begin
    dec_entry     = '0;
    dec_entry.imm = dec_imm;
    dec_entry.ill = dec_ill;
`ifdef IMM_EXT_PIPE_STATS_EN
    dec_entry.src = imm_src;
`endif
  end

  // Both handshake qualifiers come from flops, so out_ready never reaches in_ready.
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = dec_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = dec_entry;
        end else if (in_fire) begin
          skid_d  = dec_entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign imm_ext     = main_q.imm;
  assign imm_illegal = main_q.ill;

`ifdef IMM_EXT_PIPE_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_FMT];
  logic [STAT_W-1:0] ill_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FMT; f++) cnt_q[f] <= '0;
      ill_cnt_q <= '0;
    end else if (out_fire) begin
      if (main_q.ill) begin
        ill_cnt_q <= sat_inc(ill_cnt_q);
      end else begin
        for (int f = 0; f < NUM_FMT; f++) begin
          if (main_q.src == 3'(f)) cnt_q[f] <= sat_inc(cnt_q[f]);
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int f = 0; f < NUM_FMT; f++) stat_cnt[f*STAT_W +: STAT_W] = cnt_q[f];
  end

  assign stat_illegal = ill_cnt_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances share one stimulus.
module tb_imm_ext_pipe;
  import imm_ext_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;

`ifdef IMM_EXT_PIPE_STATS_EN
  logic [79:0] stat_cnt32, stat_cnt64;
  logic [15:0] stat_ill32, stat_ill64;
`endif

  int checks = 0;
  int errors = 0;

  imm_ext_pipe #(.XLEN(32), .ILEN(32)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready32),
    .instr       (instr),
    .imm_src     (imm_src),
    .out_valid   (out_valid32),
    .out_ready   (out_ready),
    .imm_ext     (imm32),
    .imm_illegal (ill32)
`ifdef IMM_EXT_PIPE_STATS_EN
    ,
    .stat_cnt    (stat_cnt32),
    .stat_illegal(stat_ill32)
`endif
  );

  imm_ext_pipe #(.XLEN(64), .ILEN(32)) dut64 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready64),
    .instr       (instr),
    .imm_src     (imm_src),
    .out_valid   (out_valid64),
    .out_ready   (out_ready),
    .imm_ext     (imm64),
    .imm_illegal (ill64)
`ifdef IMM_EXT_PIPE_STATS_EN
    ,
    .stat_cnt    (stat_cnt64),
    .stat_illegal(stat_ill64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word for exactly one edge, then sample 1 time unit after it.
  task automatic send(input logic [31:0] w, input logic [2:0] src);
    instr    = w;
    imm_src  = src;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    imm_src   = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready32,  0);
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_imm",       imm32,       0);
    chk("rst_illegal",   ill32,       0);
    chk("rst_imm64",     imm64,       0);

    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_rise",   in_ready32,  1);
    chk("out_valid_idle",  out_valid32, 0);

    // Back-to-back formats at full throughput
    send(32'hFFC32283, IMM_I);
    chk("i_valid",   out_valid32, 1);
    chk("i_imm",     imm32, 64'hFFFFFFFC);
    chk("i_ill",     ill32, 0);
    chk("i_imm64",   imm64, 64'hFFFFFFFFFFFFFFFC);
    send(32'h00532423, IMM_S);
    chk("s_imm",     imm32, 64'h00000008);
    send(32'hFE000EE3, IMM_B);
    chk("b_imm",     imm32, 64'hFFFFFFFC);
    chk("b_imm64",   imm64, 64'hFFFFFFFFFFFFFFFC);
    send(32'h123450B7, IMM_U);
    chk("u_imm",     imm32, 64'h12345000);
    chk("u_imm64",   imm64, 64'h0000000012345000);
    send(32'h0080006F, IMM_J);
    chk("j_imm",     imm32, 64'h00000008);
    chk("j_ill",     ill32, 0);
    send(32'hFFFFFFFF, 3'b110);
    chk("ill_imm",   imm32, 0);
    chk("ill_flag",  ill32, 1);
    chk("ill_imm64", imm64, 0);
    chk("ill_flag64", ill64, 1);
    send(32'h823450B7, IMM_U);
    chk("u_neg_imm",   imm32, 64'h82345000);
    chk("u_neg_imm64", imm64, 64'hFFFFFFFF82345000);
    chk("u_neg_ill",   ill32, 0);
    @(posedge clk); #1;
    chk("drain_valid", out_valid32, 0);

    // Back-pressure: two accepted, third refused, then ordered drain
    out_ready = 1'b0;
    send(32'hFFC32283, IMM_I);
    chk("bp1_ready", in_ready32, 1);
    chk("bp1_imm",   imm32, 64'hFFFFFFFC);
    send(32'h00532423, IMM_S);
    chk("bp2_ready", in_ready32, 0);
    chk("bp2_hold",  imm32, 64'hFFFFFFFC);
    instr    = 32'h123450B7;
    imm_src  = IMM_U;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp3_ready",   in_ready32,  0);
    chk("bp3_ready64", in_ready64,  0);
    chk("bp3_valid",   out_valid32, 1);
    chk("bp3_hold",    imm32, 64'hFFFFFFFC);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_b",       imm32, 64'h00000008);
    chk("drain_b_ready", in_ready32, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drain_c",       imm32, 64'h12345000);
    chk("drain_c_valid", out_valid32, 1);
    @(posedge clk); #1;
    chk("drain_end", out_valid32, 0);

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    send(32'hFFC32283, IMM_I);
    send(32'h00532423, IMM_S);
    chk("full_ready", in_ready32, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid32, 0);
    chk("mid_rst_ready", in_ready32,  0);
    chk("mid_rst_imm",   imm32,       0);
    #3 rst = 1'b1;
    instr     = 32'h0080006F;
    imm_src   = IMM_J;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready32,  1);
    chk("post_rst_valid", out_valid32, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_first_valid", out_valid32, 1);
    chk("post_rst_first_imm",   imm32, 64'h00000008);
    @(posedge clk); #1;
    chk("post_rst_done", out_valid32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
